// File: rtl/fir_bank_ctrl.sv
// fir_bank_ctrl: coefficient-load and per-sample MAC sweep sequencer for the banked FIR.
// Host writes are steered to one coefficient bank; each accepted strobe reads every tap of all banks.
//
// state  | meaning
// S_IDLE | after reset, waiting for the first coefficient update request
// S_LOAD | host writes steered into the addressed bank
// S_WAIT | coefficients ready, waiting for a sample strobe
// S_RUN  | read sweep, one tap per cycle across all banks
// S_SUM  | one-cycle sum phase, filter output valid
module fir_bank_ctrl #(
  parameter int P_BANKS = 4,
  parameter int P_TAPS  = 10,
  parameter int P_DW    = 16,
  parameter int P_AW    = 4,
  parameter int P_IW    = 6
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_b_i,
  input  logic                      en_sample_i,
  input  logic                      coeff_update_i,
  input  logic                      csn_ram_i,
  input  logic                      wrn_ram_i,
  input  logic [P_IW-1:0]           num_of_coeff_i,
  input  logic signed [P_DW-1:0]    wr_dt_ram_i,
  output logic [P_BANKS-1:0]        csn_ram_o,
  output logic [P_BANKS-1:0]        wrn_ram_o,
  output logic [P_BANKS*P_AW-1:0]   addr_ram_o,
  output logic [P_BANKS*P_DW-1:0]   wr_dt_ram_o,
  output logic [P_AW-1:0]           sel_o,
  output logic                      en_delay_o,
  output logic                      en_add_o,
  output logic                      en_acc_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      err_idx_o,
  output logic                      overrun_o
);

  localparam int              N_COEFF  = P_BANKS * P_TAPS;
  localparam logic [P_AW-1:0] LAST_TAP = P_AW'(P_TAPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RUN, S_SUM} state_e;

  state_e          state_q;
  logic [P_AW-1:0] cnt_q;
  logic            en_mac_q;
  logic            err_idx_q;
  logic            overrun_q;

  logic [31:0] idx_w;
  logic        wr_req_w;
  logic        idx_ok_w;
  logic        load_wr_w;

  assign idx_w     = 32'(num_of_coeff_i);
  assign wr_req_w  = !csn_ram_i && !wrn_ram_i;
  assign idx_ok_w  = idx_w < 32'(N_COEFF);
  assign load_wr_w = (state_q == S_LOAD) && wr_req_w && idx_ok_w;

  always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      en_mac_q  <= 1'b0;
      err_idx_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      en_mac_q <= (state_q == S_RUN);
      // a strobe during a sweep is dropped; the sweep itself is never cut short
      if (en_sample_i && (state_q == S_RUN || state_q == S_SUM))
        overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (coeff_update_i && wr_req_w) begin
            state_q   <= S_LOAD;
            err_idx_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (wr_req_w && !idx_ok_w)
            err_idx_q <= 1'b1;
          if (!coeff_update_i)
            state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (coeff_update_i) begin
            state_q   <= S_LOAD;
            err_idx_q <= 1'b0;
          end else if (en_sample_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (cnt_q == LAST_TAP) begin
            state_q <= S_SUM;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SUM:   state_q <= S_WAIT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // reads are Moore from state/counter; the load path follows the host inputs directly
  always_comb begin
    csn_ram_o   = '1;
    wrn_ram_o   = '1;
    addr_ram_o  = '0;
    wr_dt_ram_o = '0;
    if (state_q == S_RUN) begin
      csn_ram_o = '0;
      for (int b = 0; b < P_BANKS; b++)
        addr_ram_o[b*P_AW +: P_AW] = cnt_q;
    end else if (load_wr_w) begin
      for (int b = 0; b < P_BANKS; b++) begin
        if (idx_w >= 32'(b * P_TAPS) && idx_w < 32'((b + 1) * P_TAPS)) begin
          csn_ram_o[b]                = 1'b0;
          wrn_ram_o[b]                = 1'b0;
          addr_ram_o[b*P_AW +: P_AW]  = P_AW'(idx_w - 32'(b * P_TAPS));
          wr_dt_ram_o[b*P_DW +: P_DW] = wr_dt_ram_i;
        end
      end
    end
  end

  assign en_delay_o = (state_q == S_WAIT) && !coeff_update_i && en_sample_i;
  assign sel_o      = (state_q == S_RUN) ? cnt_q : '0;
  assign done_o     = (state_q == S_SUM);
  assign busy_o     = (state_q == S_RUN) || (state_q == S_SUM);
  assign en_add_o   = en_mac_q;
  assign en_acc_o   = en_mac_q;
  assign err_idx_o  = err_idx_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_fir_bank_ctrl.sv
// Scoreboard bench for fir_bank_ctrl: a cycle-timeline model queues expected events,
// a monitor process matches them against what the controller presents each cycle.
module tb_fir_bank_ctrl;

  localparam int NB = 4;
  localparam int NT = 10;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int IW = 6;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_WAIT = 2;

  logic             clk;
  logic             rst_b;
  logic             strobe;
  logic             flag;
  logic             cs_n;
  logic             wr_n;
  logic [IW-1:0]    idx;
  logic [DW-1:0]    wdat;
  logic [NB-1:0]    csn_o;
  logic [NB-1:0]    wrn_o;
  logic [NB*AW-1:0] addr_o;
  logic [NB*DW-1:0] wdata_o;
  logic [AW-1:0]    sel_o;
  logic             en_delay_o;
  logic             en_add_o;
  logic             en_acc_o;
  logic             done_o;
  logic             busy_o;
  logic             err_o;
  logic             ovr_o;

  fir_bank_ctrl #(.P_BANKS(NB), .P_TAPS(NT), .P_DW(DW), .P_AW(AW), .P_IW(IW)) dut (
    .clk_sys_i(clk), .rst_b_i(rst_b), .en_sample_i(strobe), .coeff_update_i(flag),
    .csn_ram_i(cs_n), .wrn_ram_i(wr_n), .num_of_coeff_i(idx), .wr_dt_ram_i(wdat),
    .csn_ram_o(csn_o), .wrn_ram_o(wrn_o), .addr_ram_o(addr_o), .wr_dt_ram_o(wdata_o),
    .sel_o(sel_o), .en_delay_o(en_delay_o), .en_add_o(en_add_o), .en_acc_o(en_acc_o),
    .done_o(done_o), .busy_o(busy_o), .err_idx_o(err_o), .overrun_o(ovr_o)
  );

  typedef struct { int cyc; int bank; int addr; int data; } wr_t;
  typedef struct { int cyc; int sel; } rd_t;

  wr_t wr_q[$];
  rd_t rd_q[$];
  int  acc_q[$];
  int  done_q[$];
  int  dly_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_mode = M_IDLE;
  int free_cyc = 0;
  bit exp_err = 0;
  bit exp_ovr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event absent or unexpected (cycle %0d)", name, cyc);
  endtask

  // drive one cycle of host/strobe inputs, then advance the reference timeline
  task automatic cycle(input bit f, input bit c, input bit w, input int i, input int d, input bit s);
    bit wr_ok;
    @(posedge clk); #1;
    flag = f; cs_n = c; wr_n = w; idx = IW'(i); wdat = DW'(d); strobe = s;
    wr_ok = !c && !w;
    if (cyc < free_cyc) begin
      if (s) exp_ovr = 1;
    end else begin
      case (m_mode)
        M_IDLE: if (f && wr_ok) begin m_mode = M_LOAD; exp_err = 0; end
        M_LOAD: begin
          if (wr_ok) begin
            if (i < NB * NT) wr_q.push_back('{cyc, i / NT, i % NT, d & 'hFFFF});
            else exp_err = 1;
          end
          if (!f) m_mode = M_WAIT;
        end
        M_WAIT: begin
          if (f) begin
            m_mode = M_LOAD;
            exp_err = 0;
          end else if (s) begin
            dly_q.push_back(cyc);
            for (int t = 0; t < NT; t++) begin
              rd_q.push_back('{cyc + 1 + t, t});
              acc_q.push_back(cyc + 2 + t);
            end
            done_q.push_back(cyc + NT + 1);
            free_cyc = cyc + NT + 2;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 1, 1, 0, 0, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_csn", 64'(csn_o), 64'hF);
    chk("rst_wrn", 64'(wrn_o), 64'hF);
    chk("rst_addr", 64'(addr_o), 0);
    chk("rst_wdata", 64'(wdata_o), 0);
    chk("rst_sel", 64'(sel_o), 0);
    chk("rst_en_delay", 64'(en_delay_o), 0);
    chk("rst_en_add", 64'(en_add_o), 0);
    chk("rst_en_acc", 64'(en_acc_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_err_idx", 64'(err_o), 0);
    chk("rst_overrun", 64'(ovr_o), 0);
  endtask

  task automatic check_flags();
    @(negedge clk);
    chk("err_idx", 64'(err_o), 64'(exp_err));
    chk("overrun", 64'(ovr_o), 64'(exp_ovr));
  endtask

  task automatic model_reset();
    wr_q.delete(); rd_q.delete(); acc_q.delete(); done_q.delete(); dly_q.delete();
    m_mode = M_IDLE; free_cyc = 0; exp_err = 0; exp_ovr = 0;
  endtask

  // monitor: purge overdue expectations, then match each event the DUT shows
  logic [63:0] e_csn, e_addr, e_dat;
  initial begin
    wr_t w_e;
    rd_t r_e;
    forever begin
      @(negedge clk);
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin void'(wr_q.pop_front()); miss("write_missing"); end
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin void'(rd_q.pop_front()); miss("read_missing"); end
      while (acc_q.size() > 0 && acc_q[0] < cyc) begin void'(acc_q.pop_front()); miss("en_acc_missing"); end
      while (done_q.size() > 0 && done_q[0] < cyc) begin void'(done_q.pop_front()); miss("done_missing"); end
      while (dly_q.size() > 0 && dly_q[0] < cyc) begin void'(dly_q.pop_front()); miss("en_delay_missing"); end

      if (wrn_o != '1) begin
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
          w_e = wr_q.pop_front();
          e_csn  = 64'hF & ~(64'd1 << w_e.bank);
          e_addr = 64'(w_e.addr) << (w_e.bank * AW);
          e_dat  = 64'(w_e.data) << (w_e.bank * DW);
          chk("wr_csn", 64'(csn_o), e_csn);
          chk("wr_wrn", 64'(wrn_o), e_csn);
          chk("wr_addr", 64'(addr_o), e_addr);
          chk("wr_data", 64'(wdata_o), e_dat);
        end else miss("unexpected_write");
      end
      if (csn_o == '0 && wrn_o == '1) begin
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
          r_e = rd_q.pop_front();
          e_addr = 0;
          for (int b = 0; b < NB; b++) e_addr |= 64'(r_e.sel) << (b * AW);
          chk("rd_sel", 64'(sel_o), 64'(r_e.sel));
          chk("rd_addr", 64'(addr_o), e_addr);
          chk("rd_wdata", 64'(wdata_o), 0);
          chk("rd_busy", 64'(busy_o), 1);
        end else miss("unexpected_read");
      end
      if (en_acc_o) begin
        if (acc_q.size() > 0 && acc_q[0] == cyc) begin
          void'(acc_q.pop_front());
          chk("en_add", 64'(en_add_o), 1);
        end else miss("unexpected_en_acc");
      end
      if (done_o) begin
        if (done_q.size() > 0 && done_q[0] == cyc) begin
          void'(done_q.pop_front());
          chk("done_busy", 64'(busy_o), 1);
        end else miss("unexpected_done");
      end
      if (en_delay_o) begin
        if (dly_q.size() > 0 && dly_q[0] == cyc) begin
          void'(dly_q.pop_front());
          chk("delay_not_busy", 64'(busy_o), 0);
        end else miss("unexpected_en_delay");
      end
    end
  end

  initial begin
    int perm[NB*NT];
    int j, tmp, gap;
    rst_b = 0; strobe = 0; flag = 0; cs_n = 1; wr_n = 1; idx = '0; wdat = '0;

    // reset held with inputs toggling
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      strobe = 1'($urandom); flag = 1'($urandom); cs_n = 1'($urandom); wr_n = 1'($urandom);
      idx = IW'($urandom); wdat = DW'($urandom);
      @(negedge clk);
      check_reset_vals();
    end
    @(posedge clk); #1;
    strobe = 0; flag = 0; cs_n = 1; wr_n = 1;
    rst_b = 1;
    idle(2);

    // full coefficient load in shuffled order with random gaps
    for (int i = 0; i < NB * NT; i++) perm[i] = i;
    for (int i = NB * NT - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i)); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < NB * NT; k++) begin
      if ($urandom_range(0, 3) == 0) cycle(1, 1, 1, 0, 0, 0);
      cycle(1, 0, 0, perm[k], 100 + perm[k], 0);
    end
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 7, 999, 0);
    check_flags();

    // sweep, overrun at +5, accepted strobe at +12
    cycle(0, 1, 1, 0, 0, 1);
    idle(4);
    cycle(0, 1, 1, 0, 0, 1);
    idle(6);
    cycle(0, 1, 1, 0, 0, 1);
    idle(13);
    check_flags();

    // random strobe spacing
    for (int k = 0; k < 20; k++) begin
      gap = int'($urandom_range(1, 16));
      idle(gap - 1);
      cycle(0, 1, 1, 0, 0, 1);
    end
    idle(14);
    check_flags();

    // update flag beats a coincident strobe; out-of-range and random writes
    cycle(1, 1, 1, 0, 0, 1);
    cycle(1, 0, 0, int'($urandom_range(NB * NT, 63)), int'($urandom), 0);
    for (int k = 0; k < 6; k++) cycle(1, 0, 0, int'($urandom_range(0, NB * NT - 1)), int'($urandom), 0);
    cycle(1, 0, 0, NB * NT, 5, 0);
    cycle(0, 1, 1, 0, 0, 0);
    check_flags();
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    check_flags();
    cycle(0, 1, 1, 0, 0, 0);
    idle(2);

    // update flag raised mid-sweep is honoured only after SUM
    cycle(0, 1, 1, 0, 0, 1);
    idle(2);
    for (int k = 0; k < 12; k++) cycle(1, 0, 0, 5, int'($urandom), 0);
    cycle(0, 1, 1, 0, 0, 0);
    idle(2);
    check_flags();

    // reset pulse at tap counter 4 discards the sweep
    cycle(0, 1, 1, 0, 0, 1);
    idle(4);
    @(posedge clk); #1;
    rst_b = 0;
    model_reset();
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst_b = 1;
    idle(15);
    cycle(0, 1, 1, 0, 0, 1);
    idle(3);

    // back from IDLE: reload and run once more
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, NB * NT - 1, 1234, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 1);
    idle(14);
    check_flags();
    idle(3);

    @(negedge clk);
    chk("writes_left", 64'(wr_q.size()), 0);
    chk("reads_left", 64'(rd_q.size()), 0);
    chk("done_left", 64'(done_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
